// File: rtl/bus_pkg.sv
// Shared bus definitions for the round-robin arbiter family: FSM state
// encoding, request/response field widths and master indices.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Request/response field widths
  localparam int ADDR_W         = 32;
  localparam int DATA_W_DEFAULT = 32;

  // Master indices as carried in the grant register
  localparam logic MASTER_0 = 1'b0;
  localparam logic MASTER_1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// master that was not granted last time wins. Purely combinational so it
// can be dropped into wider arbiters later.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  // Select the winner from the request vector and the previous grant
  always_comb begin
    any   = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_rr2.sv
// Two-master round-robin arbiter in front of a single hold-until-ready slave.
// One transaction is forwarded at a time; every transaction ends with a
// return to IDLE, so the slave always sees at least one request-low cycle
// between transactions. A per-transaction timeout aborts a silent slave.
module bus_arbiter_rr2
  import bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_m0_request,
  input  logic              i_m0_rw,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic [WIDTH-1:0]  i_m0_wdata,
  output logic [WIDTH-1:0]  o_m0_rdata,
  output logic              o_m0_ready,
  output logic              o_m0_error,
  input  logic              i_m1_request,
  input  logic              i_m1_rw,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic [WIDTH-1:0]  i_m1_wdata,
  output logic [WIDTH-1:0]  o_m1_rdata,
  output logic              o_m1_ready,
  output logic              o_m1_error,
  output logic              o_request,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_address,
  output logic [WIDTH-1:0]  o_wdata,
  input  logic [WIDTH-1:0]  i_rdata,
  input  logic              i_ready,
  input  logic              i_valid
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_r;
  logic             grant_r;
  logic             last_grant_r;
  logic [CNT_W-1:0] tmo_cnt_r;

  logic             pick_s;
  logic             any_s;
  logic             busy_s;
  logic             gnt_req_s;
  logic             done_s;
  logic             tmo_s;
  logic             end_s;
  logic             resp_ready_s;
  logic             resp_error_s;
  logic [WIDTH-1:0] resp_data_s;

  rr_pick2 u_pick (
    .req   ({i_m1_request, i_m0_request}),
    .last  (last_grant_r),
    .grant (pick_s),
    .any   (any_s)
  );

  // Decode completion, timeout and the response seen by the granted master.
  // Normal completion takes priority over a timeout in the same cycle, and
  // the ready pulse is suppressed if the granted master has let go of its
  // request (protocol violation) even though the transaction still ends.
  always_comb begin
    busy_s       = (state_r == BUSY);
    gnt_req_s    = grant_r ? i_m1_request : i_m0_request;
    done_s       = busy_s & i_ready;
    tmo_s        = busy_s & ~i_ready & (tmo_cnt_r == TMO_LAST);
    end_s        = done_s | tmo_s;
    resp_ready_s = end_s & gnt_req_s;
    resp_error_s = resp_ready_s & (tmo_s | ~i_valid);
    if (resp_ready_s && done_s) begin
      resp_data_s = i_rdata;
    end else begin
      resp_data_s = '0;
    end
  end

  // Forward the granted master's request fields to the slave while BUSY
  always_comb begin
    o_request = busy_s;
    o_rw      = 1'b0;
    o_address = '0;
    o_wdata   = '0;
    if (busy_s) begin
      if (grant_r == MASTER_1) begin
        o_rw      = i_m1_rw;
        o_address = i_m1_address;
        o_wdata   = i_m1_wdata;
      end else begin
        o_rw      = i_m0_rw;
        o_address = i_m0_address;
        o_wdata   = i_m0_wdata;
      end
    end else begin
      o_rw      = 1'b0;
      o_address = '0;
      o_wdata   = '0;
    end
  end

  // Steer the response to the granted master; the other side stays quiet
  always_comb begin
    o_m0_ready = 1'b0;
    o_m0_error = 1'b0;
    o_m0_rdata = '0;
    o_m1_ready = 1'b0;
    o_m1_error = 1'b0;
    o_m1_rdata = '0;
    if (grant_r == MASTER_1) begin
      o_m1_ready = resp_ready_s;
      o_m1_error = resp_error_s;
      o_m1_rdata = resp_data_s;
    end else begin
      o_m0_ready = resp_ready_s;
      o_m0_error = resp_error_s;
      o_m0_rdata = resp_data_s;
    end
  end

  // Arbitration FSM: grant in IDLE, wait for ready or timeout in BUSY
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      grant_r      <= MASTER_0;
      last_grant_r <= MASTER_1;
      tmo_cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_r   <= pick_s;
            tmo_cnt_r <= '0;
            state_r   <= BUSY;
          end
        end
        BUSY: begin
          if (end_s) begin
            last_grant_r <= grant_r;
            state_r      <= IDLE;
          end else if (tmo_cnt_r != TMO_LAST) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
